uart_tx_sched: RTL and testbench
================================

UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter OVERSAMPLE, default 4, giving the number of tick pulses per UART bit period (legal values 2..16).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1 bit: synchronous reset, active-low.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle pulse from the baud-rate accumulator at OVERSAMPLE x baud.
REQ-005 SHALL have port req0_valid, input, 1 bit: requester 0 presents a byte.
REQ-006 SHALL have port req0_data, input, 8 bits: requester 0 byte.
REQ-007 SHALL have port req0_ready, output, 1 bit: requester 0 byte accepted this cycle.
REQ-008 SHALL have port req1_valid, input, 1 bit: requester 1 presents a byte.
REQ-009 SHALL have port req1_data, input, 8 bits: requester 1 byte.
REQ-010 SHALL have port req1_ready, output, 1 bit: requester 1 byte accepted this cycle.
REQ-011 SHALL have port txd, output, 1 bit: serial line, idle high.
REQ-012 SHALL have port busy, output, 1 bit: frame in progress (state != IDLE).
REQ-013 SHALL have port owner, output, 1 bit: index of the requester whose frame is in progress, or was last in progress.
REQ-014 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a stop bit completes.

Function
REQ-015 SHALL implement states IDLE, START, DATA, STOP; 8N1 framing, LSB first.
REQ-016 SHALL drive reqN_ready combinationally, only in IDLE with resetn high, and only for the arbitration winner.
REQ-017 SHALL grant the only valid requester when one is valid, and the requester not in owner when both are valid (round-robin).
REQ-018 SHALL accept a byte when reqN_valid and reqN_ready are both high.
- On accept: latch reqN_data into the shift register, set owner=N, go to START, clear the tick counter and bit index.
REQ-019 SHALL drive txd registered: 0 in START, current shift-register LSB in DATA, 1 in STOP and IDLE.
- txd changes on the first clock edge after the accepting cycle.
REQ-020 SHALL count tick pulses only in START, DATA and STOP; ticks in IDLE are ignored.
REQ-021 SHALL end each bit on the OVERSAMPLE-th counted tick; the counter (width ceil(log2(OVERSAMPLE))) then resets to 0.
- Start bit therefore spans acceptance to the OVERSAMPLE-th following tick.
REQ-022 SHALL, at end of START, enter DATA with bit index 0.
REQ-023 SHALL, at end of each DATA bit, shift the register right by one and increment the bit index; after bit index 7, enter STOP.
REQ-024 SHALL, at end of STOP, enter IDLE and pulse frame_done high for exactly that one cycle.
REQ-025 SHALL allow a new acceptance in the first IDLE cycle (minimum one clock of idle-high between frames).
REQ-026 SHALL treat requester data and valid as don't-care outside the accepting cycle; dropping valid never aborts a frame.
REQ-027 SHALL ensure a tick coincident with the accepting cycle is not counted.

Reset
REQ-028 SHALL, while resetn is low at a clock edge, set state=IDLE, txd=1, busy=0, frame_done=0, owner=1 (so requester 0 wins the first contention), counter=0, bit index=0.
REQ-029 SHALL force req0_ready and req1_ready to 0 while resetn is low.
REQ-030 SHALL abandon any frame on reset mid-operation: txd is high from the next edge, with no frame_done.

Verification
REQ-031 Single byte: tick every 3 clocks, req0 sends 0x55 → txd bits 0,1,0,1,0,1,0,1,0,1, each 4 ticks; one frame_done; owner=0.
REQ-032 Contention: both valid from reset with 0xA0 and 0x0B → req0 accepted first; req1 held until first IDLE after frame_done, then sent; owners 0 then 1.
REQ-033 Fairness: both valid continuously → owners alternate 0,1,0,1 over 4 frames; each ready pulses exactly once per frame won.
REQ-034 Idle ticks: 20 ticks with no valid, then req1 sends 0xFF → start bit spans exactly 4 counted ticks; txd high during the idle ticks.
REQ-035 Reset mid-frame: resetn low during DATA bit 3 of 0x3C → txd=1, busy=0 next edge, no frame_done; a subsequent 0x3C completes normally.
REQ-036 Tick on accept: tick pulses in the cycle req0_ready is high → start bit lasts the 4 ticks after that cycle, not 3.

Source files
------------

// File: rtl/uart_tx_sched_if.sv
// Requester handshake, baud tick and serial-line status bundle for uart_tx_sched.
// master = requester/environment side, slave = the transmitter.
interface uart_tx_sched_if;
   logic       tick;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       txd;
   logic       busy;
   logic       owner;
   logic       frame_done;

   modport master (
      output tick, req0_valid, req0_data, req1_valid, req1_data,
      input  req0_ready, req1_ready, txd, busy, owner, frame_done
   );

   modport slave (
      input  tick, req0_valid, req0_data, req1_valid, req1_data,
      output req0_ready, req1_ready, txd, busy, owner, frame_done
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Two-requester round-robin UART transmitter, 8N1, LSB first.
// Bit timing comes from an external oversampled tick; each bit lasts OVERSAMPLE ticks.
module uart_tx_sched #(
   parameter int unsigned OVERSAMPLE = 4
) (
   input logic             clk,
   input logic             resetn,
   uart_tx_sched_if.slave  bus
);

   localparam int unsigned CntW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam logic [CntW-1:0] CntLast = CntW'(OVERSAMPLE - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            owner_q, owner_d;
   logic            txd_q, txd_d;
   logic            done_q, done_d;

   logic grant0, grant1;
   logic ready0, ready1;
   logic accept;
   logic bit_end;

   // Round-robin: on contention the requester that did not own the last frame wins.
   assign grant0 = bus.req0_valid & (~bus.req1_valid | owner_q);
   assign grant1 = bus.req1_valid & (~bus.req0_valid | ~owner_q);

   assign ready0  = resetn & (state_q == StIdle) & grant0;
   assign ready1  = resetn & (state_q == StIdle) & grant1;
   assign accept  = ready0 | ready1;
   assign bit_end = bus.tick & (cnt_q == CntLast);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      owner_d = owner_q;
      done_d  = 1'b0;

      // Ticks only advance the bit timer while a frame is on the line.
      if (state_q != StIdle && bus.tick) begin
         cnt_d = bit_end ? '0 : cnt_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StStart;
               cnt_d   = '0;
               bit_d   = '0;
               owner_d = ready1;
               shift_d = ready1 ? bus.req1_data : bus.req0_data;
            end
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = '0;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  state_d = StStop;
               end
            end
         end
         StStop: begin
            if (bit_end) begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase

      unique case (state_d)
         StStart: txd_d = 1'b0;
         StData:  txd_d = shift_d[0];
         default: txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         owner_q <= 1'b1;
         txd_q   <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         owner_q <= owner_d;
         txd_q   <= txd_d;
         done_q  <= done_d;
      end
   end

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.txd        = txd_q;
   assign bus.busy       = (state_q != StIdle);
   assign bus.owner      = owner_q;
   assign bus.frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomised bench for uart_tx_sched: a frame-level reference model predicts every
// cycle of the line, and a line receiver feeds a scoreboard checked on frame_done.
module tb_uart_tx_sched;

   localparam int OS = 4;
   localparam int FrameTicks = 10 * OS;

   typedef struct {
      logic [7:0] data;
      logic       owner;
   } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   uart_tx_sched_if u_if ();

   uart_tx_sched #(.OVERSAMPLE(OS)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (u_if)
   );

   int n_vec = 0;
   int n_err = 0;

   // Stimulus controls
   int         tick_mode = 0;
   int         tick_per  = 3;
   bit         gap_en    = 1'b0;
   logic [7:0] src0[$];
   logic [7:0] src1[$];

   // Reference model: a frame is 10 bits of OS ticks each, counted after the accept cycle
   bit         chk_en = 1'b0;
   bit         m_busy = 1'b0;
   bit         m_done = 1'b0;
   bit         m_owner = 1'b1;
   int         m_ticks = 0;
   logic [7:0] m_data = '0;
   int         m_completed = 0;
   exp_t       sb[$];

   // Line receiver state
   bit         rx_act = 1'b0;
   int         rx_cnt = 0;
   logic [7:0] rx_byte = '0;
   logic       rx_start = 1'b1;
   logic       rx_stop = 1'b0;
   int         n_frames = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Tick generator
   initial begin
      int tcnt = 0;
      u_if.tick = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         tcnt++;
         case (tick_mode)
            0:       u_if.tick = 1'b0;
            1:       u_if.tick = ((tcnt % tick_per) == 0);
            default: u_if.tick = ($urandom_range(0, 2) == 0);
         endcase
      end
   end

   // Requester drivers: present the queue head; random valid gaps when enabled
   initial begin
      u_if.req0_valid = 1'b0;
      u_if.req0_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (src0.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            u_if.req0_valid = 1'b1;
            u_if.req0_data  = src0[0];
         end else begin
            u_if.req0_valid = 1'b0;
            u_if.req0_data  = 8'($urandom);
         end
      end
   end

   initial begin
      u_if.req1_valid = 1'b0;
      u_if.req1_data  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (src1.size() > 0 && !(gap_en && $urandom_range(0, 3) == 0)) begin
            u_if.req1_valid = 1'b1;
            u_if.req1_data  = src1[0];
         end else begin
            u_if.req1_valid = 1'b0;
            u_if.req1_data  = 8'($urandom);
         end
      end
   end

   always @(negedge clk) begin
      if (u_if.req0_valid && u_if.req0_ready) void'(src0.pop_front());
      if (u_if.req1_valid && u_if.req1_ready) void'(src1.pop_front());
   end

   // Model: check this cycle's outputs, then advance to the state after the next edge
   always @(negedge clk) begin
      bit   g0, g1, e_txd;
      int   idx;
      exp_t e;
      g0 = 1'b0;
      g1 = 1'b0;
      if (resetn && !m_busy) begin
         g0 = u_if.req0_valid && (!u_if.req1_valid || m_owner);
         g1 = u_if.req1_valid && (!u_if.req0_valid || !m_owner);
      end
      idx = m_ticks / OS;
      if (!m_busy)        e_txd = 1'b1;
      else if (idx == 0)  e_txd = 1'b0;
      else if (idx <= 8)  e_txd = m_data[idx-1];
      else                e_txd = 1'b1;

      if (chk_en) begin
         chk("txd", 32'(u_if.txd), 32'(e_txd));
         chk("busy", 32'(u_if.busy), 32'(m_busy));
         chk("frame_done", 32'(u_if.frame_done), 32'(m_done));
         chk("owner", 32'(u_if.owner), 32'(m_owner));
         chk("req0_ready", 32'(u_if.req0_ready), 32'(g0));
         chk("req1_ready", 32'(u_if.req1_ready), 32'(g1));
      end

      m_done = 1'b0;
      if (!resetn) begin
         m_busy  = 1'b0;
         m_owner = 1'b1;
         m_ticks = 0;
         sb.delete();
         chk_en  = 1'b1;
      end else if (!m_busy) begin
         if (g0 || g1) begin
            m_busy  = 1'b1;
            m_ticks = 0;
            m_owner = g1;
            m_data  = g1 ? u_if.req1_data : u_if.req0_data;
            e.data  = m_data;
            e.owner = m_owner;
            sb.push_back(e);
         end
      end else if (u_if.tick) begin
         m_ticks++;
         if (m_ticks == FrameTicks) begin
            m_busy = 1'b0;
            m_done = 1'b1;
            m_completed++;
         end
      end
   end

   // Monitor: receive the line mid-bit and compare against the scoreboard on frame_done
   always @(negedge clk) begin
      exp_t e;
      int   b;
      if (!resetn || !chk_en) begin
         rx_act = 1'b0;
      end else begin
         if (u_if.frame_done) begin
            if (sb.size() == 0) begin
               chk("frame_done_unexpected", 32'(u_if.frame_done), 32'd0);
            end else begin
               e = sb.pop_front();
               n_frames++;
               chk("frame_byte", 32'(rx_byte), 32'(e.data));
               chk("frame_owner", 32'(u_if.owner), 32'(e.owner));
               chk("start_bit", 32'(rx_start), 32'd0);
               chk("stop_bit", 32'(rx_stop), 32'd1);
            end
         end
         if (!rx_act && u_if.txd === 1'b0) begin
            rx_act = 1'b1;
            rx_cnt = 0;
         end
         if (rx_act && u_if.tick) begin
            rx_cnt++;
            if (((rx_cnt - 1) % OS) == OS / 2) begin
               b = (rx_cnt - 1) / OS;
               if (b == 0)      rx_start = u_if.txd;
               else if (b <= 8) rx_byte[b-1] = u_if.txd;
               else             rx_stop = u_if.txd;
            end
            if (rx_cnt == FrameTicks) rx_act = 1'b0;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #1 resetn = 1'b0;
      @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   task automatic wait_idle(input int bound, input string what);
      int  n = 0;
      bit  ok;
      do begin
         @(negedge clk);
         #1;
         n++;
         ok = (src0.size() == 0) && (src1.size() == 0) && !m_busy && !m_done;
      end while (!ok && n < bound);
      n_vec++;
      if (!ok) begin
         n_err++;
         $display("FAIL timeout_%s: still busy after %0d cycles, required idle", what, n);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;
      @(negedge clk);
      #1;
      chk("reset_txd", 32'(u_if.txd), 32'd1);
      chk("reset_owner", 32'(u_if.owner), 32'd1);

      // Single byte, tick every 3 clocks
      tick_mode = 1;
      tick_per  = 3;
      src0.push_back(8'h55);
      wait_idle(2000, "single");

      // Contention straight from reset
      do_reset();
      src0.push_back(8'hA0);
      src1.push_back(8'h0B);
      wait_idle(4000, "contention");

      // Fairness over four back-to-back frames
      src0.push_back(8'h12);
      src0.push_back(8'h34);
      src1.push_back(8'h56);
      src1.push_back(8'h78);
      wait_idle(8000, "fairness");

      // Idle ticks ignored, then requester 1
      repeat (60) @(posedge clk);
      src1.push_back(8'hFF);
      wait_idle(2000, "idle_ticks");

      // Reset during data bit 3, then a clean retry
      src0.push_back(8'h3C);
      begin
         int n = 0;
         do begin
            @(negedge clk);
            #1;
            n++;
         end while (!(m_busy && (m_ticks / OS) == 4) && n < 2000);
         chk("reach_data_bit3", 32'(m_busy && (m_ticks / OS) == 4), 32'd1);
      end
      do_reset();
      src0.push_back(8'h3C);
      wait_idle(2000, "after_reset");

      // Tick every cycle, so one lands on the accepting cycle
      tick_per = 1;
      src0.push_back(8'h5A);
      src1.push_back(8'hC3);
      wait_idle(2000, "tick_on_accept");

      // Randomised traffic with random ticks and valid gaps
      tick_mode = 2;
      gap_en    = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 0) src0.push_back(8'($urandom_range(0, 255)));
         else                           src1.push_back(8'($urandom_range(0, 255)));
      end
      wait_idle(30000, "random");

      repeat (5) @(negedge clk);
      chk("frames_completed", 32'(n_frames), 32'(m_completed));
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
